// File: rtl/vm_pkg.sv
// Shared definitions for the 2-bit coin interface: coin codes and the feeder state encoding.
// Used by coin_feeder, vending_machine and their benches.
package vm_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_COIN   = 3'd1,
        ST_GAP    = 3'd2,
        ST_WAIT_Q = 3'd3,
        ST_DONE   = 3'd4
    } feeder_state_t;

    // Greedy coin choice: a 10-unit coin whenever at least two 5-unit steps remain.
    function automatic logic [1:0] greedy_coin(input logic two_or_more);
        return two_or_more ? COIN_10 : COIN_5;
    endfunction

endpackage

// File: rtl/coin_feeder.sv
// Transmit side of the coin interface: pays a requested amount as greedy coin pulses with idle gaps,
// then waits for the vend strobe q and reports success, early vend or timeout.
module coin_feeder
    import vm_pkg::*;
#(
    parameter int AW      = 4,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] amount,
    input  logic          q,
    output logic [1:0]    x,
    output logic          busy,
    output logic          done,
    output logic          vend_ok,
    output logic          early,
    output logic [AW-1:0] coins
);

    // One down-counter serves both the gap and the vend timeout; they are never active together.
    localparam int TMAX = (GAP > TIMEOUT) ? GAP : TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    feeder_state_t state, state_next;

    logic [AW-1:0] remaining, remaining_next;
    logic [TW-1:0] timer, timer_next;
    logic [AW-1:0] coins_next;
    logic [1:0]    x_next;
    logic          busy_next, done_next, vend_ok_next, early_next;

    logic [AW-1:0] rem_src;
    logic [AW-1:0] coins_base;
    logic          coin_ten;

    always_ff @(posedge clk or negedge rst) begin : state_reg
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so every register
            // samples the pre-edge values regardless of block ordering.
            state <= state_next;
        end
    end

    always_comb begin : next_state_logic
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (start) state_next = (amount != '0) ? ST_COIN : ST_DONE;
            end
            ST_COIN: begin
                state_next = q ? ST_DONE : ST_GAP;
            end
            ST_GAP: begin
                if (q)                state_next = ST_DONE;
                else if (timer == '0) state_next = (remaining != '0) ? ST_COIN : ST_WAIT_Q;
            end
            ST_WAIT_Q: begin
                if (q || timer == '0) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state, so a coin is already on x during its COIN cycle.
    always_comb begin : output_logic
        // NOTE: every signal gets a default before the case so no path leaves it unassigned,
        // which would otherwise infer a latch.
        rem_src        = (state == ST_IDLE) ? amount : remaining;
        coin_ten       = (rem_src >= AW'(2));
        coins_base     = (state == ST_IDLE) ? '0 : coins;

        x_next         = COIN_NONE;
        remaining_next = remaining;
        timer_next     = timer;
        coins_next     = coins;
        vend_ok_next   = vend_ok;
        early_next     = early;
        busy_next      = (state_next != ST_IDLE);
        done_next      = (state_next == ST_DONE);

        if (state == ST_IDLE && start) begin
            coins_next   = '0;
            early_next   = 1'b0;
            vend_ok_next = 1'b0;
        end

        unique case (state_next)
            ST_COIN: begin
                x_next         = greedy_coin(coin_ten);
                remaining_next = rem_src - (coin_ten ? AW'(2) : AW'(1));
                coins_next     = (coins_base == '1) ? coins_base : coins_base + 1'b1;
            end
            ST_GAP: begin
                timer_next = (state == ST_GAP) ? timer - 1'b1 : TW'(GAP - 1);
            end
            ST_WAIT_Q: begin
                timer_next = (state == ST_WAIT_Q) ? timer - 1'b1 : TW'(TIMEOUT - 1);
            end
            ST_DONE: begin
                // q in COIN or GAP abandons the rest of the payment.
                vend_ok_next   = (state != ST_IDLE) && q;
                early_next     = q && (state == ST_COIN || state == ST_GAP);
                remaining_next = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin : datapath_reg
        if (!rst) begin
            x         <= COIN_NONE;
            busy      <= 1'b0;
            done      <= 1'b0;
            vend_ok   <= 1'b0;
            early     <= 1'b0;
            coins     <= '0;
            remaining <= '0;
            timer     <= '0;
        end else begin
            x         <= x_next;
            busy      <= busy_next;
            done      <= done_next;
            vend_ok   <= vend_ok_next;
            early     <= early_next;
            coins     <= coins_next;
            remaining <= remaining_next;
            timer     <= timer_next;
        end
    end

endmodule

// File: tb/tb_coin_feeder.sv
// Directed bench for coin_feeder: coin codes and completion results are scoreboarded in queues
// and compared when the DUT drives them.
module tb_coin_feeder;
    import vm_pkg::*;

    localparam int AW      = 4;
    localparam int GAP     = 1;
    localparam int TIMEOUT = 8;

    typedef struct {
        logic          vend_ok;
        logic          early;
        logic [AW-1:0] coins;
        int            lat;
    } result_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] amount;
    logic          q;
    logic [1:0]    x;
    logic          busy, done, vend_ok, early;
    logic [AW-1:0] coins;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int t0          = 0;
    int gap_left    = 0;

    logic [1:0] coin_q[$];
    result_t    res_q[$];

    coin_feeder #(.AW(AW), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .amount (amount),
        .q      (q),
        .x      (x),
        .busy   (busy),
        .done   (done),
        .vend_ok(vend_ok),
        .early  (early),
        .coins  (coins)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Coin-level monitor: legal codes, minimum idle gap, and in-order coin values.
    always @(negedge clk) begin
        if (!rst) begin
            gap_left = 0;
        end else begin
            check("x_legal", {31'b0, x == 2'b11}, 32'd0);
            if (gap_left > 0) begin
                check("x_gap_idle", {30'b0, x}, {30'b0, COIN_NONE});
                gap_left--;
            end else if (x != COIN_NONE) begin
                if (coin_q.size() == 0) begin
                    check("x_unexpected_coin", {30'b0, x}, {30'b0, COIN_NONE});
                end else begin
                    check("x_coin", {30'b0, x}, {30'b0, coin_q.pop_front()});
                end
                gap_left = GAP;
            end
        end
    end

    // Drive a start strobe for one cycle; afterwards we sit in cycle 1 of the transaction.
    task automatic launch(input logic [AW-1:0] amt);
        amount = amt;
        start  = 1'b1;
        t0     = cyc;
        tick(1);
        start  = 1'b0;
    endtask

    task automatic pulse_q;
        q = 1'b1;
        tick(1);
        q = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        result_t r;
        while (!done && (cyc - t0) < budget) tick(1);
        if (res_q.size() == 0) begin
            check({tag, "_no_expect"}, 32'd1, 32'd0);
            return;
        end
        r = res_q.pop_front();
        if (!done) begin
            check({tag, "_done_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, "_latency"}, cyc - t0, r.lat);
        check({tag, "_vend_ok"}, {31'b0, vend_ok}, {31'b0, r.vend_ok});
        check({tag, "_early"}, {31'b0, early}, {31'b0, r.early});
        check({tag, "_coins"}, {28'b0, coins}, {28'b0, r.coins});
        check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd1);
        check({tag, "_coins_drained"}, coin_q.size(), 32'd0);
        tick(1);
        check({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
        check({tag, "_done_one_cycle"}, {31'b0, done}, 32'd0);
        check({tag, "_coins_hold"}, {28'b0, coins}, {28'b0, r.coins});
    endtask

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        amount = '0;
        q      = 1'b0;
        tick(2);
        check("rst_x", {30'b0, x}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_vend_ok", {31'b0, vend_ok}, 32'd0);
        check("rst_early", {31'b0, early}, 32'd0);
        check("rst_coins", {28'b0, coins}, 32'd0);
        rst = 1'b1;
        tick(2);

        // 1: amount=3 -> 10,01; q during first WAIT_Q cycle (cycle 5) -> done in cycle 6.
        coin_q.push_back(COIN_10);
        coin_q.push_back(COIN_5);
        res_q.push_back('{vend_ok: 1'b1, early: 1'b0, coins: 4'd2, lat: 6});
        launch(4'd3);
        check("t1_busy_started", {31'b0, busy}, 32'd1);
        tick(4);
        pulse_q();
        wait_done("t1", 40);
        tick(2);

        // 2: amount=1, no q -> one 01, one gap, 8 wait cycles, done in cycle 11.
        coin_q.push_back(COIN_5);
        res_q.push_back('{vend_ok: 1'b0, early: 1'b0, coins: 4'd1, lat: 11});
        launch(4'd1);
        wait_done("t2", 40);
        tick(2);

        // 3: amount=6, q in the gap after the second 10 -> early vend, third coin never sent.
        coin_q.push_back(COIN_10);
        coin_q.push_back(COIN_10);
        res_q.push_back('{vend_ok: 1'b1, early: 1'b1, coins: 4'd2, lat: 5});
        launch(4'd6);
        tick(3);
        pulse_q();
        wait_done("t3", 40);
        tick(3);
        check("t3_no_late_coin", {30'b0, x}, 32'd0);

        // 4: amount=0 -> no coins, done in cycle 1; a start held through DONE is ignored.
        res_q.push_back('{vend_ok: 1'b0, early: 1'b0, coins: 4'd0, lat: 1});
        amount = '0;
        start  = 1'b1;
        t0     = cyc;
        tick(1);
        amount = 4'd2;
        wait_done("t4", 10);
        start = 1'b0;
        check("t4_start_in_done_ignored", {31'b0, busy}, 32'd0);
        tick(2);

        // 5: amount=3 with a re-pulse of start (amount=7) while busy -> unchanged sequence, timeout.
        coin_q.push_back(COIN_10);
        coin_q.push_back(COIN_5);
        res_q.push_back('{vend_ok: 1'b0, early: 1'b0, coins: 4'd2, lat: 13});
        launch(4'd3);
        tick(1);
        amount = 4'd7;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
        wait_done("t5", 40);
        tick(2);

        // 6: amount=5, reset asserted in the second gap (cycle 4) -> immediate idle, no done.
        coin_q.push_back(COIN_10);
        coin_q.push_back(COIN_10);
        coin_q.push_back(COIN_5);
        launch(4'd5);
        tick(3);
        check("t6_in_flight", {31'b0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("t6_rst_x", {30'b0, x}, 32'd0);
        check("t6_rst_busy", {31'b0, busy}, 32'd0);
        check("t6_rst_coins", {28'b0, coins}, 32'd0);
        coin_q.delete();
        tick(2);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("t6_no_done", {31'b0, done}, 32'd0);
        end
        coin_q.push_back(COIN_10);
        res_q.push_back('{vend_ok: 1'b0, early: 1'b0, coins: 4'd1, lat: 11});
        launch(4'd2);
        check("t6_fresh_coins", {28'b0, coins}, 32'd1);
        wait_done("t6", 40);
        tick(2);

        check("end_coin_queue_empty", coin_q.size(), 32'd0);
        check("end_result_queue_empty", res_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
